// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ariane_pkg
// Brief    : Core-wide types shared by the issue stage (scoreboard entry).
// Revision : 1.0 - initial release
// ============================================================================
package ariane_pkg;

   // Default number of instructions moved from decode towards rename per cycle
   localparam int NR_ISSUE_PORTS = 2;

   typedef enum logic [3:0] {
      NONE,
      LOAD,
      STORE,
      ALU,
      CTRL_FLOW,
      MULT,
      CSR,
      FPU
   } fu_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  trans_id;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
      logic        use_imm;
      logic        use_pc;
      logic        is_compressed;
   } scoreboard_entry_t;

endpackage
`default_nettype wire

// File: rtl/issue_dispatch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : issue_dispatch_buffer_pkg
// Brief    : Types and helpers for the decode-to-rename dispatch buffer.
// Revision : 1.0 - initial release
// ============================================================================
package issue_dispatch_buffer_pkg;

   typedef ariane_pkg::scoreboard_entry_t scoreboard_entry_t;

   localparam int NR_ISSUE_PORTS = ariane_pkg::NR_ISSUE_PORTS;

   function automatic int wrap_idx(input int value, input int depth);
      return value % depth;
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_dispatch_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface : issue_dispatch_buffer_if
// Brief     : Producer/consumer bundle of the dispatch buffer (decode -> rename).
// Revision  : 1.0 - initial release
// ============================================================================
interface issue_dispatch_buffer_if
   import issue_dispatch_buffer_pkg::*;
#(
   parameter int NR_PORTS = NR_ISSUE_PORTS,
   parameter int DEPTH    = 8
);
   localparam int c_USAGE_W = $clog2(DEPTH) + 1;

   logic                             flush_i;
   scoreboard_entry_t [NR_PORTS-1:0] instr_i;
   logic [NR_PORTS-1:0]              instr_valid_i;
   logic [NR_PORTS-1:0]              is_ctrl_flow_i;
   logic [NR_PORTS-1:0]              instr_ack_o;
   scoreboard_entry_t [NR_PORTS-1:0] instr_o;
   logic [NR_PORTS-1:0]              instr_valid_o;
   logic [NR_PORTS-1:0]              instr_ack_i;
   logic [c_USAGE_W-1:0]             usage_o;
   logic                             full_o;
   logic                             empty_o;

   modport master (
      output flush_i, instr_i, instr_valid_i, is_ctrl_flow_i, instr_ack_i,
      input  instr_ack_o, instr_o, instr_valid_o, usage_o, full_o, empty_o
   );

   modport slave (
      input  flush_i, instr_i, instr_valid_i, is_ctrl_flow_i, instr_ack_i,
      output instr_ack_o, instr_o, instr_valid_o, usage_o, full_o, empty_o
   );

endinterface
`default_nettype wire

// File: rtl/prefix_len.sv
`default_nettype none
// ============================================================================
// Module   : prefix_len
// Brief    : Length of the run of set bits starting at bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module prefix_len #(
   parameter int WIDTH = 2,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_bits,
   output logic [LEN_W-1:0] o_len
);

   always_comb begin
      logic w_run;
      w_run = 1'b1;
      o_len = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_run = w_run & i_bits[i];
         o_len = o_len + LEN_W'(w_run);
      end
   end

endmodule
`default_nettype wire

// File: rtl/issue_dispatch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : issue_dispatch_buffer
// Brief    : Multi-port circular buffer between decode and rename in issue.
// Revision : 1.0 - initial release
// ============================================================================
module issue_dispatch_buffer
   import issue_dispatch_buffer_pkg::*;
#(
   parameter int NR_PORTS = NR_ISSUE_PORTS,
   parameter int DEPTH    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   issue_dispatch_buffer_if.slave bus
);

   localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_UW = $clog2(DEPTH) + 1;
   localparam int c_CW = $clog2(NR_PORTS + 1);

   scoreboard_entry_t   r_mem [DEPTH];
   logic [DEPTH-1:0]    r_ctrl;
   logic [c_AW-1:0]     r_rd_ptr;
   logic [c_AW-1:0]     r_wr_ptr;
   logic [c_UW-1:0]     r_usage;

   logic [c_CW-1:0]     w_in_len;
   logic [c_CW-1:0]     w_offer_len;
   logic [c_CW-1:0]     w_deq_len;
   logic [c_UW-1:0]     w_free;
   logic [c_UW-1:0]     w_enq;
   logic [c_UW-1:0]     w_deq;
   logic [NR_PORTS-1:0] w_head_ctrl;
   logic [NR_PORTS-1:0] w_offer_cand;
   logic [NR_PORTS-1:0] w_valid_o;
   logic [NR_PORTS-1:0] w_ack_o;
   logic [NR_PORTS-1:0] w_taken;

   function automatic logic [c_AW-1:0] ptr_add(input logic [c_AW-1:0] ptr, input int n);
      return c_AW'(wrap_idx(int'(ptr) + n, DEPTH));
   endfunction

   // Head window: port k always shows entry rd_ptr + k
   always_comb begin
      w_head_ctrl = '0;
      bus.instr_o = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         w_head_ctrl[k] = r_ctrl[ptr_add(r_rd_ptr, k)];
         bus.instr_o[k] = r_mem[ptr_add(r_rd_ptr, k)];
      end
   end

   // A port is a candidate when it holds data and its predecessor is not
   // control flow; the prefix cut makes any control-flow entry the youngest.
   always_comb begin
      w_offer_cand    = '0;
      w_offer_cand[0] = (r_usage != '0);
      for (int k = 1; k < NR_PORTS; k++) begin
         w_offer_cand[k] = (c_UW'(k) < r_usage) && !w_head_ctrl[k-1];
      end
   end

   prefix_len #(.WIDTH(NR_PORTS)) u_offer_len (
      .i_bits (w_offer_cand),
      .o_len  (w_offer_len)
   );

   prefix_len #(.WIDTH(NR_PORTS)) u_enq_len (
      .i_bits (bus.instr_valid_i),
      .o_len  (w_in_len)
   );

   prefix_len #(.WIDTH(NR_PORTS)) u_deq_len (
      .i_bits (w_taken),
      .o_len  (w_deq_len)
   );

   // Free space comes from registered usage only, so slots released by a
   // same-cycle dequeue are not refilled until the next cycle.
   always_comb begin
      w_free    = c_UW'(DEPTH) - r_usage;
      w_enq     = (c_UW'(w_in_len) < w_free) ? c_UW'(w_in_len) : w_free;
      w_ack_o   = '0;
      w_valid_o = '0;
      if (bus.flush_i || !rst_ni) begin
         w_enq = '0;
      end
      for (int k = 0; k < NR_PORTS; k++) begin
         w_ack_o[k]   = (c_UW'(k) < w_enq);
         w_valid_o[k] = !bus.flush_i && (c_CW'(k) < w_offer_len);
      end
   end

   assign w_taken = w_valid_o & bus.instr_ack_i;
   assign w_deq   = c_UW'(w_deq_len);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_usage  <= '0;
      end else if (bus.flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_usage  <= '0;
      end else begin
         r_wr_ptr <= ptr_add(r_wr_ptr, int'(w_enq));
         r_rd_ptr <= ptr_add(r_rd_ptr, int'(w_deq));
         r_usage  <= r_usage + w_enq - w_deq;
      end
   end

   // Payload storage is only read where usage marks it valid
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NR_PORTS; k++) begin
         if (w_ack_o[k]) begin
            r_mem[ptr_add(r_wr_ptr, k)]  <= bus.instr_i[k];
            r_ctrl[ptr_add(r_wr_ptr, k)] <= bus.is_ctrl_flow_i[k];
         end
      end
   end

   assign bus.instr_ack_o   = w_ack_o;
   assign bus.instr_valid_o = w_valid_o;
   assign bus.usage_o       = r_usage;
   assign bus.full_o        = (r_usage == c_UW'(DEPTH));
   assign bus.empty_o       = (r_usage == '0);

endmodule
`default_nettype wire
